bp_fe_fetch_buffer: RTL and testbench
=====================================

Name: bp_fe_fetch_buffer

Overview:
- Decoupling FIFO directly downstream of the FE PC-generation stage.
- Captures each fetched instruction: PC, instruction word, branch metadata and fetch exception code.
- Presents entries in order to the FE-queue packer through a valid/ready handshake.
- Back-pressures fetch when full, flushes on redirect, and halts enqueue after a faulting fetch until the backend redirects.

Parameters:
- vaddr_width_p, 39, virtual address width.
- instr_width_p, 32, instruction width.
- br_meta_width_p, 64, width of forwarded branch metadata.
- els_p, 4, entry count; power of two, >= 2.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- enq_v_i  in  1  fetch result valid.
- enq_ready_o  out  1  buffer can accept; gates upstream next_pc_yumi.
- enq_pc_i  in  vaddr_width_p  fetch PC.
- enq_instr_i  in  instr_width_p  fetched instruction.
- enq_br_meta_i  in  br_meta_width_p  branch metadata.
- enq_exc_i  in  2  0 none, 1 itlb miss, 2 icache miss, 3 instr page fault.
- flush_i  in  1  redirect; discard all entries.
- deq_v_o  out  1  head entry valid.
- deq_ready_i  in  1  consumer accepts head.
- deq_pc_o  out  vaddr_width_p  head PC.
- deq_instr_o  out  instr_width_p  head instruction.
- deq_br_meta_o  out  br_meta_width_p  head metadata.
- deq_exc_o  out  2  head exception code.
- count_o  out  $clog2(els_p)+1  occupancy.
- halted_o  out  1  in HALT state.

Behaviour:
- Clock and reset: one clock, clk_i. Reset is asynchronous and active-low on reset_n_i.
- Reset values: rptr=wptr=0, count_o=0, deq_v_o=0, enq_ready_o=1, halted_o=0, state RUN. Entry storage is not reset.
- Pointers: rptr and wptr are $clog2(els_p)+1 bits, and the extra MSB is the wrap bit.
  - empty = (rptr==wptr).
  - full = index bits equal and wrap bits differ.
  - Both wrap naturally modulo 2*els_p.
- Enqueue fires when enq_v_i & enq_ready_o. It writes {pc, instr, meta, exc} at wptr[idx] and increments wptr.
- enq_ready_o = ~full & ~flush_i & (state==RUN). It does not depend on deq_ready_i, so a full buffer never accepts, even if a dequeue happens in the same cycle.
- Dequeue fires when deq_v_o & deq_ready_i and increments rptr. deq_v_o = ~empty & ~flush_i.
- Simultaneous enqueue and dequeue: both pointers advance and count is unchanged.
- Latency: an entry is visible on deq_* the cycle after it is enqueued (registered storage).
- State machine:
  - RUN -> HALT when an enqueue fires with enq_exc_i != 0. The faulting entry itself is stored.
  - HALT: enq_ready_o=0 and halted_o=1. Entries already stored continue to drain.
  - HALT -> RUN on flush_i.
- Flush:
  - In the flush cycle, deq_v_o=0 and enq_ready_o=0, and no handshake fires.
  - At the next edge, rptr=wptr=0 and state=RUN.
  - Flush takes priority over every other event.
- enq_v_i while enq_ready_o=0: the input is ignored (protocol violation). A simulation assertion fires unless in HALT or flush.
- Reset asserted mid-operation: all state clears immediately and asynchronously.
- count_o = wptr - rptr, computed at full pointer width.

Optional Feature:
- Macro: BP_FE_FETCH_BUFFER_BYPASS_EN.
- When defined:
  - If the buffer is empty, state==RUN and flush_i=0, enqueued data passes combinationally to deq_* in the same cycle.
  - deq_v_o = enq_v_i in that case.
  - If deq_ready_i is also high, the entry is consumed without being written and the pointers are unchanged.
  - enq_ready_o is unchanged, so there is no combinational path from deq_ready_i to enq_ready_o.
- When undefined: minimum latency is 1 cycle, as described above.

Decomposition:
- bp_fe_pkg holds:
  - enum bp_fe_fetch_exc_e (e_fetch_exc_none, e_itlb_miss, e_icache_miss, e_instr_page_fault).
  - enum bp_fe_fetch_buf_state_e (e_fb_run, e_fb_halt).
  - a struct macro for the entry {pc, instr, br_meta, exc} parameterised by widths.
- One sub-module, bp_fe_fetch_buffer_ptrs: read/write pointer registers, wrap logic, full/empty/count.
- Storage is a flop array in the top level.

Test Plan:
- Enqueue 4 entries (pc 0x1000, 0x1004, 0x1008, 0x100C) with deq_ready_i=0 -> count_o=4, enq_ready_o=0. Then drain with deq_ready_i=1 -> PCs emerge in order, then count_o=0 and deq_v_o=0.
- Full with enq_v_i=1 and deq_ready_i=1 -> exactly one dequeue, no enqueue, count_o 4->3. Next cycle enq_ready_o=1.
- Run 10 enqueue/dequeue pairs through els_p=4 -> pointers wrap, and data equals a reference queue on every cycle.
- Enqueue pc 0x2000 with enq_exc_i=2 -> halted_o=1 next cycle and enq_ready_o=0. The entry dequeues with deq_exc_o=2. Assert flush_i -> next cycle halted_o=0, count_o=0, enq_ready_o=1.
- Three entries held, assert flush_i together with enq_v_i -> no enqueue, deq_v_o=0 in that cycle, count_o=0 after.
- Bypass variant, empty buffer: enq pc 0x3000 with deq_ready_i=1 -> deq_pc_o=0x3000 in the same cycle, count_o stays 0. Non-bypass variant: it appears one cycle later. Also pulse reset_n_i low mid-drain -> count_o=0 and deq_v_o=0 immediately.

Source files
------------

// File: rtl/bp_fe_pkg.sv
// Shared FE fetch-buffer types: fetch exception codes, buffer state and the entry struct macro.
`ifndef BP_FE_FETCH_BUF_ENTRY_S_DEFINED
`define BP_FE_FETCH_BUF_ENTRY_S_DEFINED
`define BP_FE_FETCH_BUF_ENTRY_S_DECL(vaddr_width_mp, instr_width_mp, br_meta_width_mp) \
   typedef struct packed { \
      logic [vaddr_width_mp-1:0]   pc; \
      logic [instr_width_mp-1:0]   instr; \
      logic [br_meta_width_mp-1:0] br_meta; \
      bp_fe_fetch_exc_e            exc; \
   } bp_fe_fetch_buf_entry_s
`endif

package bp_fe_pkg;

   typedef enum logic [1:0] {
      e_fetch_exc_none   = 2'd0,
      e_itlb_miss        = 2'd1,
      e_icache_miss      = 2'd2,
      e_instr_page_fault = 2'd3
   } bp_fe_fetch_exc_e;

   typedef enum logic {
      e_fb_run  = 1'b0,
      e_fb_halt = 1'b1
   } bp_fe_fetch_buf_state_e;

endpackage

// File: rtl/bp_fe_fetch_buffer_ptrs.sv
// Read/write pointers with wrap bit; derives full, empty and occupancy. Flush zeroes both pointers.
module bp_fe_fetch_buffer_ptrs
   import bp_fe_pkg::*;
#(
   parameter int unsigned els_p = 4,
   localparam int unsigned ptr_width_lp = $clog2(els_p) + 1
)(
   input  logic                    clk_i,
   input  logic                    reset_n_i,
   input  logic                    i_flush,
   input  logic                    i_wr_inc,
   input  logic                    i_rd_inc,
   output logic [ptr_width_lp-1:0] o_wptr,
   output logic [ptr_width_lp-1:0] o_rptr,
   output logic                    o_full,
   output logic                    o_empty,
   output logic [ptr_width_lp-1:0] o_count
);

   localparam int unsigned idx_width_lp = ptr_width_lp - 1;
   localparam logic [ptr_width_lp-1:0] ptr_one_lp = ptr_width_lp'(1);

   logic [ptr_width_lp-1:0] r_wptr;
   logic [ptr_width_lp-1:0] r_rptr;

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else if (i_flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (i_wr_inc) r_wptr <= r_wptr + ptr_one_lp;
         if (i_rd_inc) r_rptr <= r_rptr + ptr_one_lp;
      end
   end

   // Same slot with opposite wrap bits means the writer has lapped the reader.
   assign o_full  = (r_wptr[idx_width_lp-1:0] == r_rptr[idx_width_lp-1:0])
                  & (r_wptr[idx_width_lp] != r_rptr[idx_width_lp]);
   assign o_empty = (r_wptr == r_rptr);
   assign o_count = r_wptr - r_rptr;
   assign o_wptr  = r_wptr;
   assign o_rptr  = r_rptr;

endmodule

// File: rtl/bp_fe_fetch_buffer.sv
// FE fetch decoupling FIFO: 1-cycle enq-to-deq latency (0 with BP_FE_FETCH_BUFFER_BYPASS_EN when empty);
// enq_ready_o drops when full, flushing or halted after a faulting fetch; deq side is valid/ready.
module bp_fe_fetch_buffer
   import bp_fe_pkg::*;
#(
   parameter int unsigned vaddr_width_p   = 39,
   parameter int unsigned instr_width_p   = 32,
   parameter int unsigned br_meta_width_p = 64,
   parameter int unsigned els_p           = 4
)(
   input  logic                       clk_i,
   input  logic                       reset_n_i,

   input  logic                       enq_v_i,
   output logic                       enq_ready_o,
   input  logic [vaddr_width_p-1:0]   enq_pc_i,
   input  logic [instr_width_p-1:0]   enq_instr_i,
   input  logic [br_meta_width_p-1:0] enq_br_meta_i,
   input  logic [1:0]                 enq_exc_i,

   input  logic                       flush_i,

   output logic                       deq_v_o,
   input  logic                       deq_ready_i,
   output logic [vaddr_width_p-1:0]   deq_pc_o,
   output logic [instr_width_p-1:0]   deq_instr_o,
   output logic [br_meta_width_p-1:0] deq_br_meta_o,
   output logic [1:0]                 deq_exc_o,

   output logic [$clog2(els_p):0]     count_o,
   output logic                       halted_o
);

   localparam int unsigned idx_width_lp = $clog2(els_p);
   localparam int unsigned ptr_width_lp = idx_width_lp + 1;

   `BP_FE_FETCH_BUF_ENTRY_S_DECL(vaddr_width_p, instr_width_p, br_meta_width_p);

   bp_fe_fetch_buf_entry_s r_mem [els_p];
   bp_fe_fetch_buf_entry_s w_enq_entry;
   bp_fe_fetch_buf_entry_s w_head_entry;
   bp_fe_fetch_buf_entry_s w_deq_entry;

   bp_fe_fetch_buf_state_e r_state;
   bp_fe_fetch_buf_state_e w_state_nxt;

   logic [ptr_width_lp-1:0] w_wptr;
   logic [ptr_width_lp-1:0] w_rptr;
   logic [ptr_width_lp-1:0] w_count;
   logic                    w_full;
   logic                    w_empty;
   logic                    w_run;
   logic                    w_bypass;
   logic                    w_enq_fire;
   logic                    w_deq_fire;
   logic                    w_wr_inc;
   logic                    w_rd_inc;

   bp_fe_fetch_buffer_ptrs #(
      .els_p (els_p)
   ) u_ptrs (
      .clk_i     (clk_i),
      .reset_n_i (reset_n_i),
      .i_flush   (flush_i),
      .i_wr_inc  (w_wr_inc),
      .i_rd_inc  (w_rd_inc),
      .o_wptr    (w_wptr),
      .o_rptr    (w_rptr),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_count   (w_count)
   );

   assign w_run       = (r_state == e_fb_run);
   assign halted_o    = (r_state == e_fb_halt);
   assign enq_ready_o = ~w_full & ~flush_i & w_run;
   assign count_o     = w_count;

`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
   assign w_bypass = w_empty & w_run & ~flush_i;
`else
   assign w_bypass = 1'b0;
`endif

   always_comb begin
      w_enq_entry         = '0;
      w_enq_entry.pc      = enq_pc_i;
      w_enq_entry.instr   = enq_instr_i;
      w_enq_entry.br_meta = enq_br_meta_i;
      w_enq_entry.exc     = bp_fe_fetch_exc_e'(enq_exc_i);
   end

   assign w_head_entry = r_mem[w_rptr[idx_width_lp-1:0]];
   assign w_deq_entry  = w_bypass ? w_enq_entry : w_head_entry;

   assign deq_v_o       = w_bypass ? enq_v_i : (~w_empty & ~flush_i);
   assign deq_pc_o      = w_deq_entry.pc;
   assign deq_instr_o   = w_deq_entry.instr;
   assign deq_br_meta_o = w_deq_entry.br_meta;
   assign deq_exc_o     = w_deq_entry.exc;

   assign w_enq_fire = enq_v_i & enq_ready_o;
   assign w_deq_fire = deq_v_o & deq_ready_i;

   // A bypassed entry consumed in its arrival cycle never touches storage or pointers.
   assign w_wr_inc = w_enq_fire & ~(w_bypass & w_deq_fire);
   assign w_rd_inc = w_deq_fire & ~w_bypass;

   always_ff @(posedge clk_i) begin
      if (w_wr_inc) r_mem[w_wptr[idx_width_lp-1:0]] <= w_enq_entry;
   end

   always_ff @(posedge clk_i or negedge reset_n_i) begin
      if (!reset_n_i) r_state <= e_fb_run;
      else            r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         e_fb_run:  if (w_enq_fire && (enq_exc_i != e_fetch_exc_none)) w_state_nxt = e_fb_halt;
         e_fb_halt: w_state_nxt = e_fb_halt;
         default:   w_state_nxt = e_fb_run;
      endcase
      if (flush_i) w_state_nxt = e_fb_run;
   end

   // Offering while not ready is only legitimate while halted or during a redirect.
   always @(posedge clk_i) begin
      assert (!(reset_n_i && enq_v_i && !enq_ready_o && w_run && !flush_i))
         else $warning("enq_v_i asserted while fetch buffer cannot accept");
   end

endmodule

// File: tb/tb_bp_fe_fetch_buffer.sv
// Directed bench for bp_fe_fetch_buffer: ordering, full/backpressure, wrap, halt, flush, latency, reset.
module tb_bp_fe_fetch_buffer;

   logic        clk_i = 1'b0;
   logic        reset_n_i;
   logic        enq_v_i;
   logic        enq_ready_o;
   logic [38:0] enq_pc_i;
   logic [31:0] enq_instr_i;
   logic [63:0] enq_br_meta_i;
   logic [1:0]  enq_exc_i;
   logic        flush_i;
   logic        deq_v_o;
   logic        deq_ready_i;
   logic [38:0] deq_pc_o;
   logic [31:0] deq_instr_o;
   logic [63:0] deq_br_meta_o;
   logic [1:0]  deq_exc_o;
   logic [2:0]  count_o;
   logic        halted_o;

   int n_checks = 0;
   int n_fail   = 0;
   logic [38:0] q[$];
   logic [38:0] pc;

   always #5 clk_i = ~clk_i;

   bp_fe_fetch_buffer dut (
      .clk_i         (clk_i),
      .reset_n_i     (reset_n_i),
      .enq_v_i       (enq_v_i),
      .enq_ready_o   (enq_ready_o),
      .enq_pc_i      (enq_pc_i),
      .enq_instr_i   (enq_instr_i),
      .enq_br_meta_i (enq_br_meta_i),
      .enq_exc_i     (enq_exc_i),
      .flush_i       (flush_i),
      .deq_v_o       (deq_v_o),
      .deq_ready_i   (deq_ready_i),
      .deq_pc_o      (deq_pc_o),
      .deq_instr_o   (deq_instr_o),
      .deq_br_meta_o (deq_br_meta_o),
      .deq_exc_o     (deq_exc_o),
      .count_o       (count_o),
      .halted_o      (halted_o)
   );

   function automatic logic [31:0] instr_of(input logic [38:0] p);
      return p[31:0] ^ 32'hA5A5_0000;
   endfunction

   function automatic logic [63:0] meta_of(input logic [38:0] p);
      return {p[31:0], ~p[31:0]};
   endfunction

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [38:0] p, input logic [1:0] exc,
                        input logic rdy, input logic fl);
      enq_v_i       = v;
      enq_pc_i      = p;
      enq_instr_i   = instr_of(p);
      enq_br_meta_i = meta_of(p);
      enq_exc_i     = exc;
      deq_ready_i   = rdy;
      flush_i       = fl;
   endtask

   initial begin
      reset_n_i = 1'b0;
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
      @(negedge clk_i); #1;
      chk("rst_count", count_o, 0);
      chk("rst_deq_v", deq_v_o, 0);
      chk("rst_enq_ready", enq_ready_o, 1);
      chk("rst_halted", halted_o, 0);
      reset_n_i = 1'b1;

      // fill to full, then drain in order
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         pc = 39'h1000 + 39'(4 * i);
         drive(1'b1, pc, 2'd0, 1'b0, 1'b0); #1;
         chk("fill_enq_ready", enq_ready_o, 1);
`ifndef BP_FE_FETCH_BUFFER_BYPASS_EN
         if (i == 0) chk("fill_first_deq_v", deq_v_o, 0);
`endif
      end
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("full_count", count_o, 4);
      chk("full_enq_ready", enq_ready_o, 0);
      chk("full_deq_v", deq_v_o, 1);
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
         pc = 39'h1000 + 39'(4 * i);
         chk("drain_deq_v", deq_v_o, 1);
         chk("drain_pc", deq_pc_o, pc);
         chk("drain_instr", deq_instr_o, instr_of(pc));
         chk("drain_meta", deq_br_meta_o, meta_of(pc));
      end
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("drained_count", count_o, 0);
      chk("drained_deq_v", deq_v_o, 0);

      // full with enq and deq offered together: only the dequeue fires
      for (int i = 0; i < 4; i++) begin
         @(negedge clk_i);
         drive(1'b1, 39'h1100 + 39'(4 * i), 2'd0, 1'b0, 1'b0);
      end
      @(negedge clk_i);
      drive(1'b1, 39'h1200, 2'd0, 1'b1, 1'b0); #1;
      chk("fullboth_enq_ready", enq_ready_o, 0);
      chk("fullboth_count", count_o, 4);
      chk("fullboth_pc", deq_pc_o, 39'h1100);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("fullboth_count_after", count_o, 3);
      chk("fullboth_enq_ready_after", enq_ready_o, 1);
      for (int i = 1; i < 4; i++) begin
         @(negedge clk_i);
         drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
         chk("fullboth_drain_pc", deq_pc_o, 39'h1100 + 39'(4 * i));
      end
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("fullboth_empty_count", count_o, 0);
      chk("fullboth_empty_deq_v", deq_v_o, 0);

      // streaming pairs around the wrap against a reference queue
      @(negedge clk_i);
      drive(1'b1, 39'h4000, 2'd0, 1'b0, 1'b0);
      q.push_back(39'h4000);
      for (int n = 1; n <= 10; n++) begin
         @(negedge clk_i);
         pc = 39'h4000 + 39'(4 * n);
         drive(1'b1, pc, 2'd0, 1'b1, 1'b0); #1;
         chk("wrap_deq_v", deq_v_o, 1);
         chk("wrap_pc", deq_pc_o, q[0]);
         chk("wrap_instr", deq_instr_o, instr_of(q[0]));
         chk("wrap_count", count_o, 1);
         void'(q.pop_front());
         q.push_back(pc);
      end
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
      chk("wrap_last_pc", deq_pc_o, q[0]);
      void'(q.pop_front());
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("wrap_end_count", count_o, 0);

      // faulting fetch halts enqueue until a flush
      @(negedge clk_i);
      drive(1'b1, 39'h2000, 2'd2, 1'b0, 1'b0); #1;
      chk("exc_enq_ready", enq_ready_o, 1);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("halt_halted", halted_o, 1);
      chk("halt_enq_ready", enq_ready_o, 0);
      chk("halt_pc", deq_pc_o, 39'h2000);
      chk("halt_exc", deq_exc_o, 2);
      @(negedge clk_i);
      drive(1'b1, 39'h2004, 2'd0, 1'b1, 1'b0); #1;
      chk("halt_drain_v", deq_v_o, 1);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("halt_drained_count", count_o, 0);
      chk("halt_still_halted", halted_o, 1);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b1); #1;
      chk("halt_flush_enq_ready", enq_ready_o, 0);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("unhalt_halted", halted_o, 0);
      chk("unhalt_count", count_o, 0);
      chk("unhalt_enq_ready", enq_ready_o, 1);

      // flush with a concurrent enqueue offer
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         drive(1'b1, 39'h5000 + 39'(4 * i), 2'd0, 1'b0, 1'b0);
      end
      @(negedge clk_i);
      drive(1'b1, 39'h500C, 2'd0, 1'b1, 1'b1); #1;
      chk("flush_count_before", count_o, 3);
      chk("flush_deq_v", deq_v_o, 0);
      chk("flush_enq_ready", enq_ready_o, 0);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0); #1;
      chk("flush_count_after", count_o, 0);
      chk("flush_deq_v_after", deq_v_o, 0);
      chk("flush_enq_ready_after", enq_ready_o, 1);

      // enqueue-to-dequeue latency on an empty buffer
      @(negedge clk_i);
      drive(1'b1, 39'h3000, 2'd0, 1'b1, 1'b0); #1;
`ifdef BP_FE_FETCH_BUFFER_BYPASS_EN
      chk("byp_deq_v", deq_v_o, 1);
      chk("byp_pc", deq_pc_o, 39'h3000);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
      chk("byp_count", count_o, 0);
      chk("byp_deq_v_after", deq_v_o, 0);
`else
      chk("lat_deq_v_same", deq_v_o, 0);
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
      chk("lat_deq_v_next", deq_v_o, 1);
      chk("lat_pc_next", deq_pc_o, 39'h3000);
      chk("lat_count_next", count_o, 1);
      @(negedge clk_i); #1;
      chk("lat_count_end", count_o, 0);
`endif

      // asynchronous reset in the middle of a drain
      for (int i = 0; i < 3; i++) begin
         @(negedge clk_i);
         drive(1'b1, 39'h6000 + 39'(4 * i), 2'd0, 1'b0, 1'b0);
      end
      @(negedge clk_i);
      drive(1'b0, '0, 2'd0, 1'b1, 1'b0); #1;
      chk("mid_pc", deq_pc_o, 39'h6000);
      @(negedge clk_i); #1;
      chk("mid_count", count_o, 2);
      #2 reset_n_i = 1'b0;
      #1;
      chk("arst_count", count_o, 0);
      chk("arst_deq_v", deq_v_o, 0);
      chk("arst_enq_ready", enq_ready_o, 1);
      drive(1'b0, '0, 2'd0, 1'b0, 1'b0);
      @(negedge clk_i);
      reset_n_i = 1'b1;
      @(negedge clk_i); #1;
      chk("post_rst_count", count_o, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
